macro_broadcast_fork: RTL

Single-entry buffered multicast fork: accepts one WIDTH-bit word from an upstream valid/ready source and presents it to up to COUNT downstream valid/ready sinks, each of which takes the word independently. It is the distribution counterpart of the OR-reduction macro. Where that macro merges COUNT lanes into one word, this block fans one word out to COUNT lanes. It is used wherever a single producer must deliver the same token to several consumers, for example a redirect/flush broadcast to multiple pipeline units.

---
 rtl/macro_broadcast_fork.sv | 34 +++
 1 files changed

// File: rtl/macro_broadcast_fork.sv
// macro_broadcast_fork: one-entry buffered multicast fork; s_valid/s_ready/s_data/s_mask in, per-sink m_valid/m_ready/m_data out, busy = entry occupied
module macro_broadcast_fork #(
  parameter int OUTPUT_WIDTH = 1,
  parameter int OUTPUT_COUNT = 1
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [OUTPUT_WIDTH-1:0]          s_data,
  input  logic [OUTPUT_COUNT-1:0]          s_mask,
  output logic [OUTPUT_COUNT-1:0]          m_valid,
  input  logic [OUTPUT_COUNT-1:0]          m_ready,
  output logic [OUTPUT_WIDTH*OUTPUT_COUNT-1:0] m_data,
  output logic                             busy
);
  logic [OUTPUT_WIDTH-1:0] d;
  logic [OUTPUT_COUNT-1:0] p, r;
  logic                    accept;
  assign r       = p & ~m_ready;
  assign s_ready = r == '0;
  assign accept  = s_valid & s_ready;
  assign m_valid = p;
  assign m_data  = {OUTPUT_COUNT{d}};
  assign busy    = |p;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      p <= '0;
      d <= '0;
    end else begin
      p <= accept ? s_mask : r;
      if (accept) d <= s_data;
    end
endmodule
